// File: rtl/compute_core.sv
// Four-thread SIMT compute core: built-in program ROM, per-thread PC and register file,
// round-robin scheduler, single-cycle execute. Optional macro MUL_EN enables opcode 3 (MUL).
module compute_core #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic clk,
  input  logic reset,
  output logic halt
);

  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned INSN_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_BRNZ = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [ADDR_WIDTH-1:0]  pc   [0:NUM_THREADS-1];
  logic [DATA_WIDTH-1:0]  regs [0:NUM_THREADS-1][0:REG_COUNT-1];
  logic [NUM_THREADS-1:0] done;
  logic [TID_W-1:0]       slot;

  logic [ADDR_WIDTH-1:0] cur_pc, next_pc, seq_pc, target;
  logic [INSN_W-1:0]     instr;
  logic [3:0]            opcode, rd, rs, rt;
  logic [7:0]            imm8;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, rd_val, result;
  logic                  active, wr_en, set_done;

  // Built-in program; every unused word is HALT.
  function automatic logic [INSN_W-1:0] rom_word(input logic [ADDR_WIDTH-1:0] addr);
    case (addr)
      ADDR_WIDTH'(0): rom_word = 16'h4105; // LDI  r1,5
      ADDR_WIDTH'(1): rom_word = 16'h121F; // ADD  r2,r1,r15
      ADDR_WIDTH'(2): rom_word = 16'h4303; // LDI  r3,3
      ADDR_WIDTH'(3): rom_word = 16'h4401; // LDI  r4,1
      ADDR_WIDTH'(4): rom_word = 16'h2334; // SUB  r3,r3,r4
      ADDR_WIDTH'(5): rom_word = 16'h9304; // BRNZ r3,4
      ADDR_WIDTH'(6): rom_word = 16'h3522; // MUL  r5,r2,r2
      default:        rom_word = 16'hF000; // HALT
    endcase
  endfunction

  // Fetch, decode and execute for the thread owning the current slot.
  always_comb begin
    cur_pc   = pc[slot];
    instr    = rom_word(cur_pc);
    opcode   = instr[15:12];
    rd       = instr[11:8];
    rs       = instr[7:4];
    rt       = instr[3:0];
    imm8     = instr[7:0];
    rs_val   = regs[slot][rs];
    rt_val   = regs[slot][rt];
    rd_val   = regs[slot][rd];
    seq_pc   = cur_pc + ADDR_WIDTH'(1);
    target   = imm8[ADDR_WIDTH-1:0];
    active   = !done[slot];
    next_pc  = seq_pc;
    result   = '0;
    wr_en    = 1'b0;
    set_done = 1'b0;
    case (opcode)
      OP_ADD:  begin result = rs_val + rt_val; wr_en = 1'b1; end
      OP_SUB:  begin result = rs_val - rt_val; wr_en = 1'b1; end
`ifdef MUL_EN
      OP_MUL:  begin result = rs_val * rt_val; wr_en = 1'b1; end
`else
      OP_MUL:  wr_en = 1'b0;
`endif
      OP_LDI:  begin result = DATA_WIDTH'(imm8); wr_en = 1'b1; end
      OP_AND:  begin result = rs_val & rt_val; wr_en = 1'b1; end
      OP_OR:   begin result = rs_val | rt_val; wr_en = 1'b1; end
      OP_XOR:  begin result = rs_val ^ rt_val; wr_en = 1'b1; end
      OP_BRZ:  if (rd_val == '0) next_pc = target;
      OP_BRNZ: if (rd_val != '0) next_pc = target;
      OP_JMP:  next_pc = target;
      OP_HALT: begin next_pc = cur_pc; set_done = 1'b1; end
      default: next_pc = seq_pc;
    endcase
    // r15 holds the thread index and is never overwritten.
    if (rd == 4'(REG_COUNT - 1)) wr_en = 1'b0;
  end

  // State update; everything freezes once halt is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      halt <= 1'b0;
      done <= '0;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= '0;
        for (int unsigned r = 0; r < REG_COUNT; r++)
          regs[t][r] <= (r == REG_COUNT - 1) ? DATA_WIDTH'(t) : '0;
      end
    end else if (!halt) begin
      slot <= slot + TID_W'(1);
      halt <= &done;
      if (active) begin
        pc[slot] <= next_pc;
        if (wr_en)    regs[slot][rd] <= result;
        if (set_done) done[slot]     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_compute_core.sv
// Bench for compute_core: ISA-level reference interpreter checked every cycle, plus
// hand-computed expectations for timing, loop sequence, final state and mid-run reset.
module tb_compute_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt;

  always #5 clk = ~clk;

  compute_core dut (.clk(clk), .reset(reset), .halt(halt));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an instruction-level interpreter over the same program text.
  logic [15:0] rom [16];
  logic [31:0] m_r [4][16];
  logic [3:0]  m_pc [4];
  bit          m_done [4];
  bit          m_halt;
  bit          m_all;
  int          cyc;

  initial begin
    rom[0] = 16'h4105; rom[1] = 16'h121F; rom[2] = 16'h4303; rom[3] = 16'h4401;
    rom[4] = 16'h2334; rom[5] = 16'h9304; rom[6] = 16'h3522; rom[7] = 16'hF000;
    for (int i = 8; i < 16; i++) rom[i] = 16'hF000;
  end

  task automatic wr(input int t, input logic [3:0] rd, input logic [31:0] v);
    if (rd != 4'd15) m_r[t][rd] = v;
  endtask

  task automatic exec(input int t);
    logic [15:0] w;
    logic [31:0] a, b, d;
    w = rom[m_pc[t]];
    a = m_r[t][w[7:4]];
    b = m_r[t][w[3:0]];
    d = m_r[t][w[11:8]];
    m_pc[t] = m_pc[t] + 4'd1;
    case (w[15:12])
      4'h1: wr(t, w[11:8], a + b);
      4'h2: wr(t, w[11:8], a - b);
`ifdef MUL_EN
      4'h3: wr(t, w[11:8], a * b);
`endif
      4'h4: wr(t, w[11:8], {24'd0, w[7:0]});
      4'h5: wr(t, w[11:8], a & b);
      4'h6: wr(t, w[11:8], a | b);
      4'h7: wr(t, w[11:8], a ^ b);
      4'h8: if (d == 0) m_pc[t] = w[3:0];
      4'h9: if (d != 0) m_pc[t] = w[3:0];
      4'hA: m_pc[t] = w[3:0];
      4'hF: begin m_pc[t] = m_pc[t] - 4'd1; m_done[t] = 1'b1; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < 4; t++) begin
        m_pc[t] = 4'd0;
        m_done[t] = 1'b0;
        for (int r = 0; r < 16; r++) m_r[t][r] = (r == 15) ? 32'(t) : 32'd0;
      end
      m_halt = 1'b0;
      cyc = 0;
    end else if (!m_halt) begin
      m_all = 1'b1;
      for (int t = 0; t < 4; t++) m_all &= m_done[t];
      if (!m_done[cyc % 4]) exec(cyc % 4);
      m_halt = m_all;
      cyc++;
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("halt", 64'(halt), 64'(m_halt));
      for (int t = 0; t < 4; t++) begin
        check($sformatf("pc[%0d]", t), 64'(dut.pc[t]), 64'(m_pc[t]));
        for (int r = 0; r < 16; r++)
          check($sformatf("r%0d[t%0d]", r, t), 64'(dut.regs[t][r]), 64'(m_r[t][r]));
      end
    end
  end

  logic [3:0] seq [12];
  logic [31:0] r5_exp [4];

  task automatic check_final(input string tag);
    check({tag, " halt"}, 64'(halt), 64'd1);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("%s pc[%0d]", tag, t), 64'(dut.pc[t]), 64'd7);
      check($sformatf("%s r1[%0d]", tag, t), 64'(dut.regs[t][1]), 64'd5);
      check($sformatf("%s r2[%0d]", tag, t), 64'(dut.regs[t][2]), 64'(5 + t));
      check($sformatf("%s r3[%0d]", tag, t), 64'(dut.regs[t][3]), 64'd0);
      check($sformatf("%s r4[%0d]", tag, t), 64'(dut.regs[t][4]), 64'd1);
      check($sformatf("%s r5[%0d]", tag, t), 64'(dut.regs[t][5]), 64'(r5_exp[t]));
      check($sformatf("%s r15[%0d]", tag, t), 64'(dut.regs[t][15]), 64'(t));
    end
  endtask

  initial begin
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2]  = 4'd3; seq[3]  = 4'd4;
    seq[4] = 4'd5; seq[5] = 4'd4; seq[6]  = 4'd5; seq[7]  = 4'd4;
    seq[8] = 4'd5; seq[9] = 4'd6; seq[10] = 4'd7; seq[11] = 4'd7;
`ifdef MUL_EN
    r5_exp[0] = 32'd25; r5_exp[1] = 32'd36; r5_exp[2] = 32'd49; r5_exp[3] = 32'd64;
`else
    for (int t = 0; t < 4; t++) r5_exp[t] = 32'd0;
`endif

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst halt", 64'(halt), 64'd0);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("rst pc[%0d]", t), 64'(dut.pc[t]), 64'd0);
      for (int r = 0; r < 15; r++)
        check($sformatf("rst r%0d[%0d]", r, t), 64'(dut.regs[t][r]), 64'd0);
      check($sformatf("rst r15[%0d]", t), 64'(dut.regs[t][15]), 64'(t));
    end

    // Run to completion, pinning the per-thread pc sequence and halt timing.
    reset = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      check($sformatf("seq pc[%0d] edge %0d", (n - 1) % 4, n),
            64'(dut.pc[(n - 1) % 4]), 64'(seq[(n - 1) / 4]));
      check($sformatf("early halt edge %0d", n), 64'(halt), 64'd0);
      if (n == 1) check("edge1 pc[1]", 64'(dut.pc[1]), 64'd0);
      if (n == 16)
        for (int t = 0; t < 4; t++)
          check($sformatf("edge16 pc[%0d]", t), 64'(dut.pc[t]), 64'd4);
    end
    @(negedge clk);
    check_final("done");

    // Halted core stays frozen.
    repeat (20) @(negedge clk);
    check_final("frozen");

    // Mid-run reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("mid pc[0]", 64'(dut.pc[0]), 64'd4);
    check("mid pc[3]", 64'(dut.pc[3]), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    check("rerst halt", 64'(halt), 64'd0);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("rerst pc[%0d]", t), 64'(dut.pc[t]), 64'd0);
      check($sformatf("rerst r1[%0d]", t), 64'(dut.regs[t][1]), 64'd0);
    end
    reset = 1'b0;
    repeat (48) @(negedge clk);
    check("rerun halt@48", 64'(halt), 64'd0);
    @(negedge clk);
    check_final("rerun");

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compute_core.md
Name: compute_core

Overview:
- Self-contained 4-thread SIMT compute core: internal program ROM, per-thread PC and register file, round-robin thread scheduler, single-cycle execute.
- All threads run the same built-in program; each thread sees its own thread ID in r15.
- Asserts `halt` once every thread has retired a HALT instruction.
- Top-level leaf core; observed through `halt` and the internal PC array.

Parameters:
- DATA_WIDTH, 32, register/ALU width.
- NUM_THREADS, 4, thread count; must be a power of two.
- REG_COUNT, 16, registers per thread.
- ADDR_WIDTH, 4, PC width; the ROM holds 2^ADDR_WIDTH 16-bit words.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- halt  output  1  registered; high when all threads are halted.

Behaviour:
- Internal state is declared as an unpacked array named `pc` [0:NUM_THREADS-1], ADDR_WIDTH bits each. It is hierarchically readable as `pc[0]`..`pc[3]`.
- Reset (sync, active-high): all pc=0, all registers=0, all done flags=0, scheduler slot=0, halt=0.
  - Reset asserted mid-run aborts everything and restarts the program from pc=0.
  - ROM contents are unaffected by reset.
- Scheduler: 2-bit slot counter, increments every cycle and wraps 3→0. The first cycle after reset executes thread 0.
  - If the slot's thread is done, the cycle is idle and no state changes.
- Execute: fetch ROM[pc[t]], decode, execute and write back in one cycle for thread t.
  - pc[t] updates at the same edge, to pc+1 (wrapping 15→0) or the branch target.
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt. imm8 = [7:0], zero-extended.
  - Branch target = imm8[ADDR_WIDTH-1:0].
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs+rt
  - 2 SUB rd=rs-rt
  - 3 MUL rd=low DATA_WIDTH bits of rs*rt
  - 4 LDI rd=imm8
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 BRZ: if rd==0, pc=target, else pc+1
  - 9 BRNZ: if rd!=0, pc=target, else pc+1
  - A JMP: pc=target
  - F HALT: set done[t], pc holds its current value
  - B–E: NOP
- Arithmetic is unsigned modulo 2^DATA_WIDTH (wrap-around, no flags).
- r15 is hardwired per thread to the thread index (zero-extended). Writes to r15 are discarded. r0–r14 are general purpose.
- `halt` is registered: it is set at the edge after the last thread's HALT edge, i.e. `halt` = AND of done flags, one cycle late.
- Once `halt` is high, no state changes until reset.
- Built-in ROM program (addr: instruction):
  - 0 LDI r1,5
  - 1 ADD r2,r1,r15
  - 2 LDI r3,3
  - 3 LDI r4,1
  - 4 SUB r3,r3,r4
  - 5 BRNZ r3,4
  - 6 MUL r5,r2,r2
  - 7 HALT
  - 8–15 HALT
- Program timing: each thread retires 12 instructions. Thread t executes at cycles 4k+t after reset release. Thread 3 retires HALT at cycle 47; `halt` is observed high from cycle 48.
- Final per-thread state: r1=5, r2=5+t, r3=0, r4=1, r5=(5+t)², pc=7.

Optional Feature:
- Macro MUL_EN.
- Defined: opcode 3 performs the multiply described above.
- Undefined: no multiplier is synthesised; opcode 3 behaves as NOP (rd unchanged, pc+1). Built-in program then ends with r5=0 in all threads.
- Timing is identical with and without the macro.

Test Plan:
- Reset held 2 cycles -> `halt`=0 and pc[0..3]=0 throughout; registers read 0.
- Release reset, run 4 cycles -> pc[0..3]=1 in order: pc[0] after edge 1, pc[3] after edge 4. After 16 cycles -> all pc=4.
- Run to completion -> `halt` rises at cycle 48 (not before). All pc=7. r5 of threads 0..3 = 25, 36, 49, 64 (MUL_EN defined) or 0 (undefined). r2 = 5, 6, 7, 8.
- Loop check -> for each thread, pc sequence 4,5,4,5,4,5,6,7. r3 decrements 3→2→1→0.
- Reset asserted for 1 cycle at cycle 15 mid-run -> next cycle all pc=0, `halt`=0. Program reruns and `halt` again rises 48 cycles after release.
- After `halt`=1, run 20 more cycles -> pc and registers unchanged, `halt` stays 1. A write attempt to r15 is ignored (r15 still equals the thread ID).
